// File: rtl/cpu_run_controller_pkg.sv
// Shared types and default constants for the RSA processor run controller.
package rsa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_CPU,
    RUN,
    DRAIN,
    DONE
  } run_state_t;

  localparam logic [31:0] DEF_DONE_ADDR  = 32'h0000_03FC;
  localparam int unsigned DEF_PIPE_DEPTH = 5;
  localparam int unsigned DEF_RST_CYCLES = 4;
  localparam int unsigned DEF_HALT_HOLD  = 3;

  // Larger of two sizes; used to dimension the shared sequencing counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_run_controller_halt_detector.sv
// Program-completion detector. Flags a halt on a store to DONE_ADDR, or when the
// fetch PC has stayed put (branch-to-self) on HALT_HOLD consecutive compares.
// All history is dropped whenever enable_i is low, so every run starts clean.
module halt_detector
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned HALT_HOLD = DEF_HALT_HOLD,
  parameter logic [31:0] DONE_ADDR = DEF_DONE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [31:0] pc_i,
  input  logic        mem_write_i,
  input  logic [31:0] alu_result_i,
  output logic        halt_o
);

  localparam int HW = $clog2(HALT_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HALT_HOLD - 1);

  logic [31:0]   pc_prev_q;
  logic          prev_valid_q;
  logic [HW-1:0] same_cnt_q;
  logic          pc_same;
  logic          store_hit;

  // No compare in the first enabled cycle: there is no previous PC yet.
  assign pc_same   = prev_valid_q && (pc_i == pc_prev_q);
  assign store_hit = mem_write_i && (alu_result_i == DONE_ADDR);
  assign halt_o    = enable_i && (store_hit || (pc_same && (same_cnt_q == HOLD_LAST)));

  // Track previous PC and the run length of equal compares while enabled.
  always_ff @(posedge clk) begin
    if (reset || !enable_i) begin
      pc_prev_q    <= '0;
      prev_valid_q <= 1'b0;
      same_cnt_q   <= '0;
    end else begin
      pc_prev_q    <= pc_i;
      prev_valid_q <= 1'b1;
      same_cnt_q   <= pc_same ? same_cnt_q + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the pipelined RSA processor: holds the core in reset, runs the
// program, detects completion, drains the pipeline and reports Done/TimedOut/CycleCount.
// Handshake: Go is a one-cycle request accepted only in IDLE or DONE; Abort always
// wins over Go and over any state transition, and is a no-op in IDLE.
module cpu_run_controller
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int unsigned HALT_HOLD  = DEF_HALT_HOLD,
  parameter logic [31:0] DONE_ADDR  = DEF_DONE_ADDR,
  parameter int unsigned CNT_W      = 32,
  parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Go,
  input  logic             Abort,
  input  logic [31:0]      PC,
  input  logic             MemWrite,
  input  logic [31:0]      ALUResult,
  output logic             CpuReset,
  output logic             CpuStart,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int unsigned SEQ_MAX = max_u(RST_CYCLES, PIPE_DEPTH);
  localparam int SW = (SEQ_MAX < 2) ? 1 : $clog2(SEQ_MAX);
  localparam logic [SW-1:0]    RST_LOAD   = SW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]    DRAIN_LOAD = SW'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 32'd1);

  run_state_t       state_q, state_d;
  logic [SW-1:0]    seq_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic             timed_out_q;
  logic             cpu_reset_q, cpu_start_q, busy_q, done_q;
  logic             halt;
  logic             go_ok;
  logic             seq_zero;

  assign go_ok    = Go && !Abort;
  assign seq_zero = (seq_cnt_q == '0);

  halt_detector #(
    .HALT_HOLD (HALT_HOLD),
    .DONE_ADDR (DONE_ADDR)
  ) u_halt (
    .clk          (clk),
    .reset        (reset),
    .enable_i     (state_q == RUN),
    .pc_i         (PC),
    .mem_write_i  (MemWrite),
    .alu_result_i (ALUResult),
    .halt_o       (halt)
  );

  // Next-state decode; halt beats timeout, Abort beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (go_ok) state_d = RESET_CPU;
      RESET_CPU: if (seq_zero) state_d = RUN;
      RUN: begin
        if (halt) state_d = DRAIN;
        else if (cycle_cnt_q == TIMEOUT_AT) state_d = DONE;
      end
      DRAIN:     if (seq_zero) state_d = DONE;
      DONE:      if (go_ok) state_d = RESET_CPU;
      default:   state_d = IDLE;
    endcase
    if (Abort) state_d = IDLE;
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_reset_q <= 1'b1;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= (state_d == IDLE) || (state_d == RESET_CPU);
      cpu_start_q <= (state_d == RUN) || (state_d == DRAIN);
      busy_q      <= (state_d == RESET_CPU) || (state_d == RUN) || (state_d == DRAIN);
      done_q      <= (state_d == DONE);
    end
  end

  // Shared reset/drain down-counter, run-cycle counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (state_d == RESET_CPU && state_q != RESET_CPU) seq_cnt_q <= RST_LOAD;
      else if (state_d == DRAIN && state_q != DRAIN)    seq_cnt_q <= DRAIN_LOAD;
      else if (!seq_zero)                               seq_cnt_q <= seq_cnt_q - 1'b1;

      if (state_d == RESET_CPU && state_q != RESET_CPU) begin
        cycle_cnt_q <= '0;
        timed_out_q <= 1'b0;
      end else begin
        if (state_q == RUN && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 1'b1;
        if (state_q == RUN && state_d == DONE)   timed_out_q <= 1'b1;
      end
    end
  end

  assign CpuReset   = cpu_reset_q;
  assign CpuStart   = cpu_start_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign TimedOut   = timed_out_q;
  assign CycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: each run is described by per-RUN-cycle stimulus
// tables; a timeline model derives when the run must end and queues the expected
// control outputs, timeout flag and cycle count for every cycle of the run.
module tb_cpu_run_controller;

  localparam int RST  = 4;
  localparam int PIPE = 5;
  localparam int HH   = 3;
  localparam int MAXC = 100;
  localparam logic [31:0] DADDR = 32'h0000_03FC;

  localparam int K_HALT    = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_ABORT   = 2;

  logic        clk = 1'b0;
  logic        reset, Go, Abort, MemWrite;
  logic [31:0] PC, ALUResult;
  logic        CpuReset, CpuStart, Busy, Done, TimedOut;
  logic [31:0] CycleCount;

  int errors = 0;
  int checks = 0;

  logic [31:0] pc_tab [0:MAXC];
  bit          mw_tab [0:MAXC];
  logic [31:0] ad_tab [0:MAXC];
  int          abort_at;
  int          kend;
  int          kind;
  logic [36:0] exp_q [$];

  cpu_run_controller #(
    .RST_CYCLES (RST),
    .PIPE_DEPTH (PIPE),
    .HALT_HOLD  (HH),
    .DONE_ADDR  (DADDR),
    .CNT_W      (32),
    .MAX_CYCLES (32'(MAXC))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Go         (Go),
    .Abort      (Abort),
    .PC         (PC),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .CpuReset   (CpuReset),
    .CpuStart   (CpuStart),
    .Busy       (Busy),
    .Done       (Done),
    .TimedOut   (TimedOut),
    .CycleCount (CycleCount)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_now();
    return 32'({CpuReset, CpuStart, Busy, Done});
  endfunction

  // Stimulus tables: PC walk (optionally freezing), store noise, optional DONE store.
  task automatic fill(input logic [31:0] base, input int hold_from, input logic [31:0] hold_pc,
                      input int store_at, input bit zero_steps);
    logic [31:0] ad;
    bit          mw;
    int          m;
    pc_tab[0] = '0; mw_tab[0] = 1'b0; ad_tab[0] = '0;
    for (int k = 1; k <= MAXC; k++) begin
      if (hold_from > 0 && k >= hold_from) pc_tab[k] = hold_pc;
      else if (k == 1) pc_tab[k] = base;
      else pc_tab[k] = pc_tab[k-1] + 32'(4 * (zero_steps ? $urandom_range(0, 2) : $urandom_range(1, 2)));
      m = $urandom_range(0, 2);
      case (m)
        0: begin mw = 1'b0; ad = DADDR; end
        1: begin mw = 1'b1; ad = DADDR + 32'd4; end
        default: begin
          mw = ($urandom_range(0, 1) == 1);
          ad = $urandom;
          if (ad == DADDR) ad = DADDR + 32'd8;
        end
      endcase
      if (k == store_at) begin mw = 1'b1; ad = DADDR; end
      mw_tab[k] = mw;
      ad_tab[k] = ad;
    end
  endtask

  // Reference model: find the RUN cycle that ends the run and why, then queue
  // expected {CpuReset,CpuStart,Busy,Done, TimedOut, CycleCount} per cycle after Go.
  task automatic build_expect(output int len);
    bit          held;
    logic [3:0]  ctl;
    logic [31:0] cnt;
    bit          to;
    int          k, d;
    kend = MAXC;
    kind = K_TIMEOUT;
    for (int c = 1; c <= MAXC; c++) begin
      held = 1'b0;
      if (c >= HH + 1) begin
        held = 1'b1;
        for (int i = 0; i < HH; i++) if (pc_tab[c-i] != pc_tab[c-i-1]) held = 1'b0;
      end
      if (abort_at == c) begin kend = c; kind = K_ABORT; break; end
      if ((mw_tab[c] && ad_tab[c] == DADDR) || held) begin kend = c; kind = K_HALT; break; end
    end
    len = RST + kend + ((kind == K_HALT) ? PIPE : 0) + 3;
    exp_q.delete();
    for (int j = 0; j < len; j++) begin
      k = j - RST + 1;
      if (j < RST) begin
        ctl = 4'b1010; cnt = '0; to = 1'b0;
      end else if (k <= kend) begin
        ctl = 4'b0110; cnt = 32'(k - 1); to = 1'b0;
      end else begin
        d   = k - kend;
        cnt = 32'(kend);
        to  = (kind == K_TIMEOUT);
        if (kind == K_ABORT) ctl = 4'b1000;
        else if (kind == K_HALT && d <= PIPE) ctl = 4'b0110;
        else ctl = 4'b0001;
      end
      exp_q.push_back({ctl, to, cnt});
    end
  endtask

  // Driver: Go pulse, then per-cycle stimulus and scoreboard compare.
  task automatic do_run(input string name, input int ghost);
    int          len, k, ghost_j;
    logic [36:0] e;
    build_expect(len);
    ghost_j = (ghost >= 0) ? (ghost % (RST + kend)) : -1;
    Go = 1'b1; Abort = 1'b0;
    step();
    Go = 1'b0;
    for (int j = 0; j < len; j++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_ctl_j%0d", name, j), ctl_now(), 32'(e[36:33]));
      chk($sformatf("%s_to_j%0d", name, j), 32'(TimedOut), 32'(e[32]));
      chk($sformatf("%s_cnt_j%0d", name, j), CycleCount, e[31:0]);
      k = j - RST + 1;
      Go = (j == ghost_j);
      Abort = 1'b0;
      if (j >= RST && k <= kend) begin
        PC = pc_tab[k]; MemWrite = mw_tab[k]; ALUResult = ad_tab[k];
        Abort = (abort_at == k);
      end else begin
        PC = $urandom; MemWrite = 1'b1; ALUResult = DADDR;
      end
      step();
    end
    Go = 1'b0; Abort = 1'b0;
  endtask

  initial begin
    int mode;
    reset = 1'b1; Go = 1'b0; Abort = 1'b0; PC = '0; MemWrite = 1'b0; ALUResult = '0;
    abort_at = 0;
    step(); step();
    chk("reset_ctl", ctl_now(), 32'h8);
    chk("reset_cnt", CycleCount, 32'd0);
    chk("reset_to", 32'(TimedOut), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_ctl", ctl_now(), 32'h8);

    // Abort alone in IDLE, then Go together with Abort: both leave it idle.
    Abort = 1'b1; step(); Abort = 1'b0;
    chk("abort_idle_ctl", ctl_now(), 32'h8);
    Go = 1'b1; Abort = 1'b1; step(); Go = 1'b0; Abort = 1'b0;
    chk("go_abort_ctl0", ctl_now(), 32'h8);
    step();
    chk("go_abort_ctl1", ctl_now(), 32'h8);

    // Store to DONE_ADDR at RUN cycle 20.
    fill(32'h0000_0100, 0, '0, 20, 1'b0); abort_at = 0;
    do_run("t2_store20", -1);
    // PC frozen at 0x40 from RUN cycle 10 (rerun from DONE).
    fill(32'h0000_1000, 10, 32'h40, 0, 1'b0); abort_at = 0;
    do_run("t3_hold", -1);
    // Never halts: timeout at MAX_CYCLES.
    fill(32'h0000_2000, 0, '0, 0, 1'b0); abort_at = 0;
    do_run("t4_timeout", -1);
    // Go in DONE after a timeout; store coincides with the timeout cycle.
    fill(32'h0000_3000, 0, '0, MAXC, 1'b0); abort_at = 0;
    do_run("t6_tie", -1);
    // Another timeout, then Abort in DONE keeps count and sticky flag.
    fill(32'h0000_4000, 0, '0, 0, 1'b0); abort_at = 0;
    do_run("t4b_timeout", -1);
    Abort = 1'b1; step(); Abort = 1'b0;
    chk("abort_done_ctl", ctl_now(), 32'h8);
    chk("abort_done_cnt", CycleCount, 32'(MAXC));
    chk("abort_done_to", 32'(TimedOut), 32'd1);
    // Abort at RUN cycle 7 with a stray Go at RUN cycle 3.
    fill(32'h0000_5000, 0, '0, 0, 1'b0); abort_at = 7;
    do_run("t5_abort", RST + 2);
    // Completion store on the very first RUN cycle.
    fill(32'h0000_6000, 0, '0, 1, 1'b0); abort_at = 0;
    do_run("t7_store1", -1);

    // Synchronous reset in the middle of a run.
    MemWrite = 1'b0; ALUResult = '0;
    Go = 1'b1; step(); Go = 1'b0;
    for (int i = 0; i < RST + 5; i++) begin
      PC = 32'h0000_7000 + 32'(4 * i);
      step();
    end
    chk("midrun_cnt", CycleCount, 32'd5);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrun_rst_ctl", ctl_now(), 32'h8);
    chk("midrun_rst_cnt", CycleCount, 32'd0);
    chk("midrun_rst_to", 32'(TimedOut), 32'd0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      mode = $urandom_range(0, 3);
      abort_at = 0;
      case (mode)
        0: fill($urandom & ~32'h3, 0, '0, $urandom_range(1, MAXC), 1'b0);
        1: fill($urandom & ~32'h3, $urandom_range(2, MAXC), $urandom, 0, 1'b0);
        2: fill($urandom & ~32'h3, 0, '0, 0, 1'b1);
        default: begin
          fill($urandom & ~32'h3, 0, '0, ($urandom_range(0, 1) == 1) ? $urandom_range(1, MAXC) : 0, 1'b1);
          abort_at = $urandom_range(1, MAXC);
        end
      endcase
      do_run($sformatf("rnd%0d_m%0d", r, mode), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1000) : -1);
    end

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
